ts_pack_fifo: RTL and testbench

Parametrised bit-packing FIFO for the TS recorder data path. It accepts fixed-width symbols (default 10-bit) on a valid/ready input and packs them densely into a circular register array of wider storage words (default 32-bit), with symbols straddling word boundaries. It returns the symbols in order on a valid/ready output. It sits between the TS capture/sub-sampling logic and the memory-side writer, and replaces the fixed 10-in-32 test packer with full/empty flow control, wrap-around and flush.

---
 rtl/ts_pack_pkg.sv | 31 +++
 rtl/ts_pack_mem.sv | 54 +++++
 rtl/ts_pack_fifo.sv | 88 ++++++++
 tb/tb_ts_pack_fifo.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ts_pack_pkg.sv
// Shared constants and helpers for the TS bit-packing FIFO.
package ts_pack_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  function automatic int unsigned total_bits(input int unsigned depth, input int unsigned word_w);
    return depth * word_w;
  endfunction

  function automatic int unsigned cap_syms(input int unsigned total, input int unsigned sym_w);
    return total / sym_w;
  endfunction

  function automatic int unsigned ptr_width(input int unsigned total);
    return (total > 1) ? clog2(total) : 1;
  endfunction

  // Bit pointers only ever land on symbol boundaries, so wrapping to 0 is exact.
  function automatic int unsigned wrap_add(input int unsigned ptr, input int unsigned step,
                                           input int unsigned limit);
    int unsigned s;
    s = ptr + step;
    return (s >= limit) ? 0 : s;
  endfunction

endpackage

// File: rtl/ts_pack_mem.sv
// DEPTH x WORD_W register array with bit-addressed symbol insert/extract across two words.
module ts_pack_mem
  import ts_pack_pkg::*;
#(
  parameter int unsigned SYM_W  = 10,
  parameter int unsigned WORD_W = 32,
  parameter int unsigned DEPTH  = 20,
  parameter int unsigned PTR_W  = 10
) (
  input  logic             CLOCK,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_ptr,
  input  logic [SYM_W-1:0] wr_data,
  input  logic [PTR_W-1:0] rd_ptr,
  output logic [SYM_W-1:0] rd_data
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? clog2(DEPTH) : 1;
  localparam int unsigned WIN_W = 2 * WORD_W;
  localparam logic [WIN_W-1:0] SYM_MASK = WIN_W'({SYM_W{1'b1}});

  logic [WORD_W-1:0] mem [DEPTH];

  logic [31:0]       wr_off, rd_off;
  logic [IDX_W-1:0]  wr_cur, wr_nxt, rd_cur, rd_nxt;
  logic              wr_straddle;
  logic [WIN_W-1:0]  wr_old, wr_new, rd_win;

  always_comb begin
    wr_cur      = IDX_W'(32'(wr_ptr) / WORD_W);
    wr_off      = 32'(wr_ptr) % WORD_W;
    wr_nxt      = (wr_cur == IDX_W'(DEPTH - 1)) ? '0 : wr_cur + IDX_W'(1);
    wr_straddle = (wr_off + SYM_W) > WORD_W;
    // Two adjacent words viewed as one window; the next word is the upper half.
    wr_old      = {mem[wr_nxt], mem[wr_cur]};
    wr_new      = (wr_old & ~(SYM_MASK << wr_off)) | (WIN_W'(wr_data) << wr_off);
  end

  always_comb begin
    rd_cur  = IDX_W'(32'(rd_ptr) / WORD_W);
    rd_off  = 32'(rd_ptr) % WORD_W;
    rd_nxt  = (rd_cur == IDX_W'(DEPTH - 1)) ? '0 : rd_cur + IDX_W'(1);
    rd_win  = {mem[rd_nxt], mem[rd_cur]};
    rd_data = SYM_W'(rd_win >> rd_off);
  end

  always_ff @(posedge CLOCK) begin
    if (wr_en) begin
      mem[wr_cur] <= wr_new[WORD_W-1:0];
      if (wr_straddle) mem[wr_nxt] <= wr_new[WIN_W-1:WORD_W];
    end
  end

endmodule

// File: rtl/ts_pack_fifo.sv
// Bit-packing symbol FIFO: pointers, occupancy, handshakes and registered output stage.
module ts_pack_fifo
  import ts_pack_pkg::*;
#(
  parameter int unsigned SYM_W  = 10,
  parameter int unsigned WORD_W = 32,
  parameter int unsigned DEPTH  = 20,
  localparam int unsigned CAP   = cap_syms(total_bits(DEPTH, WORD_W), SYM_W),
  localparam int unsigned CNT_W = clog2(CAP + 1)
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic             FLUSH,
  input  logic             WR_VALID,
  output logic             WR_READY,
  input  logic [SYM_W-1:0] DATA_IN,
  output logic             RD_VALID,
  input  logic             RD_READY,
  output logic [SYM_W-1:0] DATA_OUT,
  output logic [CNT_W-1:0] COUNT,
  output logic             FULL,
  output logic             EMPTY
);

  localparam int unsigned TOTAL_BITS = total_bits(DEPTH, WORD_W);
  localparam int unsigned PTR_W      = ptr_width(TOTAL_BITS);
  localparam int unsigned LIMIT      = CAP * SYM_W;

  logic [PTR_W-1:0] wr_bit, rd_bit, wr_bit_nxt, rd_bit_nxt;
  logic [CNT_W-1:0] count;
  logic             rd_valid;
  logic [SYM_W-1:0] data_out, mem_rd;
  logic             wr_ready, wr_fire, load;

  assign wr_ready   = count < CNT_W'(CAP);
  assign wr_fire    = WR_VALID && wr_ready;
  assign load       = (count != '0) && (!rd_valid || RD_READY);
  assign wr_bit_nxt = PTR_W'(wrap_add(32'(wr_bit), SYM_W, LIMIT));
  assign rd_bit_nxt = PTR_W'(wrap_add(32'(rd_bit), SYM_W, LIMIT));

  ts_pack_mem #(
    .SYM_W  (SYM_W),
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_mem (
    .CLOCK   (CLOCK),
    .wr_en   (wr_fire && !FLUSH),
    .wr_ptr  (wr_bit),
    .wr_data (DATA_IN),
    .rd_ptr  (rd_bit),
    .rd_data (mem_rd)
  );

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_bit   <= '0;
      rd_bit   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      data_out <= '0;
    end else if (FLUSH) begin
      wr_bit   <= '0;
      rd_bit   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      data_out <= '0;
    end else begin
      if (wr_fire) wr_bit <= wr_bit_nxt;
      if (load) begin
        rd_bit   <= rd_bit_nxt;
        data_out <= mem_rd;
        rd_valid <= 1'b1;
      end else if (rd_valid && RD_READY) begin
        rd_valid <= 1'b0;
      end
      count <= count + CNT_W'(wr_fire) - CNT_W'(load);
    end
  end

  assign WR_READY = wr_ready;
  assign RD_VALID = rd_valid;
  assign DATA_OUT = data_out;
  assign COUNT    = count;
  assign FULL     = count == CNT_W'(CAP);
  assign EMPTY    = (count == '0) && !rd_valid;

endmodule

// File: tb/tb_ts_pack_fifo.sv
// Scoreboard bench for ts_pack_fifo at default geometry (10-bit symbols, 20 x 32-bit words).
module tb_ts_pack_fifo;

  localparam int unsigned SYM_W  = 10;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned DEPTH  = 20;
  localparam int unsigned CAP    = 64;
  localparam int unsigned CNT_W  = 7;

  logic             CLOCK = 1'b0;
  logic             RESET_N = 1'b0;
  logic             FLUSH = 1'b0;
  logic             WR_VALID = 1'b0;
  logic             WR_READY;
  logic [SYM_W-1:0] DATA_IN = '0;
  logic             RD_VALID;
  logic             RD_READY = 1'b0;
  logic [SYM_W-1:0] DATA_OUT;
  logic [CNT_W-1:0] COUNT;
  logic             FULL;
  logic             EMPTY;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [SYM_W-1:0] q[$];
  bit m_valid = 0;
  bit m_zero  = 1;

  always #5 CLOCK = ~CLOCK;

  ts_pack_fifo #(
    .SYM_W  (SYM_W),
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH)
  ) dut (
    .CLOCK    (CLOCK),
    .RESET_N  (RESET_N),
    .FLUSH    (FLUSH),
    .WR_VALID (WR_VALID),
    .WR_READY (WR_READY),
    .DATA_IN  (DATA_IN),
    .RD_VALID (RD_VALID),
    .RD_READY (RD_READY),
    .DATA_OUT (DATA_OUT),
    .COUNT    (COUNT),
    .FULL     (FULL),
    .EMPTY    (EMPTY)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Called just after a falling edge with inputs already driven; advances one clock.
  task automatic step();
    int unsigned m_count;
    bit m_ready, fire, load, pop;
    m_count = q.size() - (m_valid ? 1 : 0);
    m_ready = m_count < CAP;
    check("wr_ready", 32'(WR_READY), 32'(m_ready));
    check("count", 32'(COUNT), m_count);
    check("rd_valid", 32'(RD_VALID), 32'(m_valid));
    check("full", 32'(FULL), 32'(m_count == CAP));
    check("empty", 32'(EMPTY), 32'(m_count == 0 && !m_valid));
    if (m_valid) check("data_out", 32'(DATA_OUT), 32'(q[0]));
    else if (m_zero) check("data_out_clr", 32'(DATA_OUT), 32'h0);
    fire = WR_VALID && m_ready;
    load = m_count > 0 && (!m_valid || RD_READY);
    pop  = m_valid && RD_READY;
    if (FLUSH) begin
      q.delete();
      m_valid = 0;
      m_zero  = 1;
    end else begin
      if (pop) void'(q.pop_front());
      if (fire) q.push_back(DATA_IN);
      if (load) begin
        m_valid = 1;
        m_zero  = 0;
      end else if (pop) begin
        m_valid = 0;
      end
    end
    @(posedge CLOCK);
    @(negedge CLOCK);
  endtask

  task automatic drive(input bit wv, input logic [SYM_W-1:0] d, input bit rr);
    WR_VALID = wv;
    DATA_IN  = d;
    RD_READY = rr;
    step();
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_wr_ready"}, 32'(WR_READY), 32'h1);
    check({tag, "_rd_valid"}, 32'(RD_VALID), 32'h0);
    check({tag, "_count"}, 32'(COUNT), 32'h0);
    check({tag, "_empty"}, 32'(EMPTY), 32'h1);
    check({tag, "_full"}, 32'(FULL), 32'h0);
    check({tag, "_data_out"}, 32'(DATA_OUT), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [SYM_W-1:0] strad [4];
    strad[0] = 10'h3FF; strad[1] = 10'h001; strad[2] = 10'h2AA; strad[3] = 10'h155;

    @(negedge CLOCK);
    check_reset_state("por");
    RESET_N = 1'b1;

    // Straddle: fourth symbol occupies word0[31:30] and word1[7:0]
    for (int i = 0; i < 4; i++) drive(1, strad[i], 0);
    drive(0, '0, 0);
    check("strad_count", 32'(COUNT), 32'd3);
    check("strad_valid", 32'(RD_VALID), 32'h1);
    check("strad_first", 32'(DATA_OUT), 32'h3FF);
    for (int i = 0; i < 5; i++) drive(0, '0, 1);

    // Full: 66 write attempts with the consumer stalled
    for (int i = 0; i < 66; i++) drive(1, 10'(i + 100), 0);
    check("full_count", 32'(COUNT), CAP);
    check("full_flag", 32'(FULL), 32'h1);
    check("full_wr_ready", 32'(WR_READY), 32'h0);
    check("full_held", q.size(), CAP + 1);
    for (int i = 0; i < 70; i++) drive(0, '0, 1);
    check("full_drained", 32'(EMPTY), 32'h1);

    // Wrap: continuous stream through three pointer wraps
    for (int i = 0; i < 200; i++) drive(1, 10'(i), 1);
    for (int i = 0; i < 4; i++) drive(0, '0, 1);
    check("wrap_drained", 32'(EMPTY), 32'h1);

    // Simultaneous write and load with COUNT held at 1
    drive(1, 10'h0A0, 0);
    drive(1, 10'h0A1, 0);
    for (int i = 0; i < 10; i++) begin
      drive(1, 10'(10'h0B0 + i), 1);
      check("simul_count", 32'(COUNT), 32'd1);
    end
    for (int i = 0; i < 4; i++) drive(0, '0, 1);

    // Flush with a concurrent write
    for (int i = 0; i < 21; i++) drive(1, 10'(i + 300), 0);
    check("pre_flush_count", 32'(COUNT), 32'd20);
    FLUSH = 1'b1;
    drive(1, 10'h3EE, 0);
    FLUSH = 1'b0;
    check("flush_count", 32'(COUNT), 32'd0);
    check("flush_valid", 32'(RD_VALID), 32'h0);
    check("flush_empty", 32'(EMPTY), 32'h1);
    drive(1, 10'h123, 0);
    drive(0, '0, 0);
    check("post_flush_valid", 32'(RD_VALID), 32'h1);
    check("post_flush_data", 32'(DATA_OUT), 32'h123);
    drive(0, '0, 1);

    // Random traffic
    for (int i = 0; i < 300; i++)
      drive(1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)), 1'($urandom_range(0, 2) != 0));

    // Asynchronous reset in the middle of a write burst
    for (int i = 0; i < 7; i++) drive(1, 10'(i + 500), 0);
    WR_VALID = 1'b1;
    DATA_IN  = 10'h2F0;
    #2 RESET_N = 1'b0;
    #1 check_reset_state("async_rst");
    @(posedge CLOCK);
    @(negedge CLOCK);
    check_reset_state("rst_hold");
    RESET_N = 1'b1;
    q.delete();
    m_valid = 0;
    m_zero  = 1;
    drive(1, 10'h0C3, 1);
    drive(0, '0, 1);
    drive(0, '0, 1);
    check("post_rst_empty", 32'(EMPTY), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
